// File: rtl/inst_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_pkg
//   Shared definitions for the instruction memory / program loader slice:
//   default geometry, the NOP returned while the memory is unavailable,
//   download FSM state encodings and the hold-flag encoding used when the
//   loader's hold request is merged into the core's 3-bit hold_flag.
// ---------------------------------------------------------------------------
package inst_mem_loader_pkg;

    // Default geometry: 4096 x 32-bit words, word address is log2(4096).
    localparam int DEF_DEPTH  = 4096;
    localparam int DEF_ADDR_W = 12;

    // addi x0, x0, 0 -- returned while loading or for out-of-range fetches.
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    // Download engine states.
    typedef enum logic [1:0] {
        DL_IDLE  = 2'd0,
        DL_RECV  = 2'd1,
        DL_WRITE = 2'd2,
        DL_DONE  = 2'd3
    } dl_state_e;

    // Core hold_flag encodings relevant to the loader.
    localparam logic [2:0] HOLD_NONE   = 3'b000;
    localparam logic [2:0] HOLD_LOADER = 3'b111;  // stall PC and every pipeline register

    // Merge the loader's hold request into the core's hold_flag. The loader
    // stall dominates because the fetch path only returns NOPs meanwhile.
    function automatic logic [2:0] merge_hold(input logic [2:0] core_hold,
                                              input logic       hold_req);
        logic [2:0] flag;
        if (hold_req) begin
            flag = HOLD_LOADER;
        end else begin
            flag = core_hold;
        end
        return flag;
    endfunction

endpackage

// File: rtl/inst_mem_loader_inst_ram.sv
// ---------------------------------------------------------------------------
// inst_ram
//   DEPTH x 32 storage with one synchronous write port and one asynchronous
//   read port. Contents are intentionally not reset so the array can map onto
//   distributed RAM.
//   Ports:
//     clk    - system clock
//     we     - write enable, sampled on the rising edge
//     waddr  - write word address
//     wdata  - write data
//     raddr  - read word address
//     rdata  - read data (combinational)
// ---------------------------------------------------------------------------
module inst_ram
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH];

    // Single write port, driven only by the download engine.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//   Instruction memory for the fetch stage plus a byte-stream download engine
//   that fills it with a program. Fetch reads are combinational so the
//   fetch stage's if_id register captures the word on the next edge.
//   Ports:
//     clk, rst_n   - clock, asynchronous active-low reset
//     pc_i         - fetch byte address
//     ins_o        - instruction at pc_i (NOP while loading / out of range)
//     dl_start_i   - one-cycle pulse starting a download
//     dl_len_i     - number of words to load, sampled with dl_start_i
//     dl_valid_i   - dl_byte_i is valid
//     dl_byte_i    - download byte, little-endian within each word
//     dl_ready_o   - engine accepts a byte this cycle
//     dl_busy_o    - download in progress
//     dl_done_o    - one-cycle pulse after the last word is written
//     hold_req_o   - stall request to the core while downloading
// ---------------------------------------------------------------------------
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] ins_o,
    input  logic        dl_start_i,
    input  logic [15:0] dl_len_i,
    input  logic        dl_valid_i,
    input  logic [7:0]  dl_byte_i,
    output logic        dl_ready_o,
    output logic        dl_busy_o,
    output logic        dl_done_o,
    output logic        hold_req_o
);

    // One extra bit so a full-memory length (DEPTH itself) is representable.
    localparam int               LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    dl_state_e          state_r, state_s;
    logic [ADDR_W-1:0]  word_cnt_r, word_cnt_s;
    logic [1:0]         byte_cnt_r, byte_cnt_s;
    logic [LEN_W-1:0]   len_q_r, len_q_s;
    logic [31:0]        buffer_r, buffer_s;
    logic               ready_r, busy_r, done_r;
    logic               last_word_s;
    logic               ram_we_s;
    logic [ADDR_W-1:0]  rd_idx_s;
    logic [31:0]        ram_rdata_s;
    logic               pc_oob_s;
    logic               pc_lsb_unused_s;

    // Next-state and datapath updates for the download engine.
    always_comb begin
        state_s     = state_r;
        word_cnt_s  = word_cnt_r;
        byte_cnt_s  = byte_cnt_r;
        len_q_s     = len_q_r;
        buffer_s    = buffer_r;
        last_word_s = ({1'b0, word_cnt_r} == (len_q_r - LEN_W'(1)));

        case (state_r)
            DL_IDLE: begin
                if (dl_start_i && (dl_len_i != 16'd0)) begin
                    // Longer requests are clamped to the memory size.
                    if (32'(dl_len_i) > 32'(DEPTH)) begin
                        len_q_s = DEPTH_LEN;
                    end else begin
                        len_q_s = LEN_W'(dl_len_i);
                    end
                    word_cnt_s = {ADDR_W{1'b0}};
                    byte_cnt_s = 2'd0;
                    state_s    = DL_RECV;
                end else begin
                    state_s = DL_IDLE;
                end
            end
            DL_RECV: begin
                if (dl_valid_i && ready_r) begin
                    buffer_s[{byte_cnt_r, 3'b000} +: 8] = dl_byte_i;
                    // Wraps 3 -> 0 on the word's final byte.
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        state_s = DL_WRITE;
                    end else begin
                        state_s = DL_RECV;
                    end
                end else begin
                    state_s = DL_RECV;
                end
            end
            DL_WRITE: begin
                if (last_word_s) begin
                    state_s = DL_DONE;
                end else begin
                    word_cnt_s = word_cnt_r + ADDR_W'(1);
                    state_s    = DL_RECV;
                end
            end
            DL_DONE: begin
                state_s = DL_IDLE;
            end
            default: begin
                state_s = DL_IDLE;
            end
        endcase
    end

    // Control registers and registered status outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= DL_IDLE;
            word_cnt_r <= {ADDR_W{1'b0}};
            byte_cnt_r <= 2'd0;
            len_q_r    <= {LEN_W{1'b0}};
            buffer_r   <= 32'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_cnt_r <= word_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            len_q_r    <= len_q_s;
            buffer_r   <= buffer_s;
            ready_r    <= (state_s == DL_RECV);
            busy_r     <= (state_s != DL_IDLE);
            done_r     <= (state_s == DL_DONE);
        end
    end

    assign ram_we_s        = (state_r == DL_WRITE);
    assign rd_idx_s        = pc_i[ADDR_W+1:2];
    assign pc_oob_s        = |pc_i[31:ADDR_W+2];
    // Fetch addresses are word aligned; the byte offset carries no information.
    assign pc_lsb_unused_s = ^pc_i[1:0];

    inst_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_inst_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (word_cnt_r),
        .wdata (buffer_r),
        .raddr (rd_idx_s),
        .rdata (ram_rdata_s)
    );

    // Fetch read path; NOP while loading so the core never sees a half-written program.
    always_comb begin
        if (pc_oob_s || busy_r) begin
            ins_o = NOP_INS;
        end else begin
            ins_o = ram_rdata_s;
        end
    end

    assign dl_ready_o = ready_r;
    assign dl_busy_o  = busy_r;
    assign hold_req_o = busy_r;
    assign dl_done_o  = done_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] ins_o;
    logic        dl_start_i = 1'b0;
    logic [15:0] dl_len_i = 16'd0;
    logic        dl_valid_i = 1'b0;
    logic [7:0]  dl_byte_i = 8'd0;
    logic        dl_ready_o;
    logic        dl_busy_o;
    logic        dl_done_o;
    logic        hold_req_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int lost = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_ins;
    } rd_vec_t;

    rd_vec_t rd_tab [10];

    inst_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_i       (pc_i),
        .ins_o      (ins_o),
        .dl_start_i (dl_start_i),
        .dl_len_i   (dl_len_i),
        .dl_valid_i (dl_valid_i),
        .dl_byte_i  (dl_byte_i),
        .dl_ready_o (dl_ready_o),
        .dl_busy_o  (dl_busy_o),
        .dl_done_o  (dl_done_o),
        .hold_req_o (hold_req_o)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (dl_done_o === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic start_dl(input logic [15:0] len);
        dl_start_i = 1'b1;
        dl_len_i   = len;
        tick();
        dl_start_i = 1'b0;
        dl_len_i   = 16'd0;
    endtask

    // Offer one byte until the engine takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        dl_valid_i = 1'b1;
        dl_byte_i  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (dl_ready_o === 1'b1) ok = 1'b1;
            tick();
        end
        dl_valid_i = 1'b0;
        if (!ok) lost++;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic read_chk(input string name, input logic [31:0] pc, input logic [31:0] exp);
        pc_i = pc;
        #1;
        chk(name, ins_o, exp);
    endtask

    initial begin
        rd_tab[0] = '{32'h0000_0000, 32'h0000_0013};
        rd_tab[1] = '{32'h0000_0004, 32'h0010_0093};
        rd_tab[2] = '{32'h0000_0008, 32'h0020_0113};
        rd_tab[3] = '{32'h0000_000C, 32'hDEAD_BEEF};
        rd_tab[4] = '{32'h0000_000F, 32'hDEAD_BEEF};
        rd_tab[5] = '{32'h0000_0006, 32'h0010_0093};
        rd_tab[6] = '{32'h0000_4000, NOP};
        rd_tab[7] = '{32'h0000_4008, NOP};
        rd_tab[8] = '{32'h8000_000C, NOP};
        rd_tab[9] = '{32'hFFFF_FFFC, NOP};

        // Reset state
        tick();
        tick();
        chk1("rst_ready", dl_ready_o, 1'b0);
        chk1("rst_busy", dl_busy_o, 1'b0);
        chk1("rst_done", dl_done_o, 1'b0);
        chk1("rst_hold", hold_req_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Bytes offered while idle are not accepted
        dl_valid_i = 1'b1;
        dl_byte_i  = 8'h55;
        tick();
        chk1("idle_ready", dl_ready_o, 1'b0);
        tick();
        dl_valid_i = 1'b0;

        // Zero-length start is ignored
        start_dl(16'd0);
        chk1("zero_len_busy", dl_busy_o, 1'b0);
        tick();
        chk1("zero_len_busy2", dl_busy_o, 1'b0);
        chk("zero_len_done", done_cnt, 32'd0);

        // Basic two-word download with gaps and an ignored second start
        start_dl(16'd2);
        chk1("dl_busy", dl_busy_o, 1'b1);
        chk1("dl_hold", hold_req_o, 1'b1);
        chk1("dl_ready", dl_ready_o, 1'b1);
        read_chk("busy_nop", 32'h0000_0004, NOP);
        send_byte(8'h13);
        send_byte(8'h00);
        tick();
        tick();
        send_byte(8'h00);
        send_byte(8'h00);
        chk1("write_ready", dl_ready_o, 1'b0);
        send_byte(8'h93);
        send_byte(8'h00);
        start_dl(16'd5);
        send_byte(8'h10);
        send_byte(8'h00);
        chk1("last_write_ready", dl_ready_o, 1'b0);
        chk1("last_write_busy", dl_busy_o, 1'b1);
        chk1("last_write_done", dl_done_o, 1'b0);
        tick();
        chk1("done_pulse", dl_done_o, 1'b1);
        chk1("done_hold", hold_req_o, 1'b1);
        tick();
        chk1("after_done", dl_done_o, 1'b0);
        chk1("after_busy", dl_busy_o, 1'b0);
        chk1("after_hold", hold_req_o, 1'b0);
        chk("done_cnt1", done_cnt, 32'd1);
        read_chk("basic_w1", 32'h0000_0004, 32'h0010_0093);
        read_chk("basic_w0", 32'h0000_0000, 32'h0000_0013);

        // Four-word load, then table-driven read checks
        start_dl(16'd4);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_word(32'h0020_0113);
        send_word(32'hDEAD_BEEF);
        tick();
        tick();
        chk("done_cnt2", done_cnt, 32'd2);
        for (int i = 0; i < 10; i++) begin
            pc_i = rd_tab[i].pc;
            #1;
            chk($sformatf("rd_tab[%0d]", i), ins_o, rd_tab[i].exp_ins);
        end

        // Reset after 6 bytes of a 2-word load
        start_dl(16'd2);
        send_word(32'hCAFE_F00D);
        send_byte(8'h44);
        send_byte(8'h33);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", dl_busy_o, 1'b0);
        chk1("mid_rst_ready", dl_ready_o, 1'b0);
        chk1("mid_rst_done", dl_done_o, 1'b0);
        chk1("mid_rst_hold", hold_req_o, 1'b0);
        read_chk("mid_rst_w0", 32'h0000_0000, 32'hCAFE_F00D);
        read_chk("mid_rst_w1", 32'h0000_0004, 32'h0010_0093);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_done", done_cnt, 32'd2);
        start_dl(16'd1);
        send_word(32'h1234_5678);
        tick();
        tick();
        chk("done_cnt3", done_cnt, 32'd3);
        read_chk("post_rst_w0", 32'h0000_0000, 32'h1234_5678);
        read_chk("post_rst_w1", 32'h0000_0004, 32'h0010_0093);

        // Oversized length clamps to the full memory
        start_dl(16'hFFFF);
        for (int w = 0; w < 4096; w++) send_word(32'hA500_0000 | 32'(w));
        chk1("clamp_write_ready", dl_ready_o, 1'b0);
        tick();
        chk1("clamp_done", dl_done_o, 1'b1);
        tick();
        chk1("clamp_idle", dl_busy_o, 1'b0);
        chk("done_cnt4", done_cnt, 32'd4);
        read_chk("clamp_w0", 32'h0000_0000, 32'hA500_0000);
        read_chk("clamp_w2048", 32'h0000_2000, 32'hA500_0800);
        read_chk("clamp_w4095", 32'h0000_3FFC, 32'hA500_0FFF);

        chk("byte_timeouts", lost, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Instruction-side memory and responder for the fetch unit's PC/instruction interface.
- Returns the instruction word for the fetch address combinationally, in the same cycle, so the fetch stage's if_id register captures it on the next edge.
- Contains a byte-stream download engine (fed from a UART/debug bridge) that fills the memory with a program.
- Asserts a hold request to the core while a download is in progress.

Parameters:
DEPTH, 4096, number of 32-bit words in the memory.
ADDR_W, 12, word-address width; must equal log2(DEPTH).
NOP_INS, 32'h00000013, instruction returned while loading or when the address is out of range (addi x0,x0,0).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pc_i  in  32  fetch byte address from the PC
ins_o  out  32  instruction at pc_i
dl_start_i  in  1  one-cycle pulse that starts a download
dl_len_i  in  16  number of words to load; sampled on dl_start_i
dl_valid_i  in  1  dl_byte_i is valid
dl_byte_i  in  8  download data byte, little-endian within each word
dl_ready_o  out  1  engine accepts a byte this cycle
dl_busy_o  out  1  download in progress
dl_done_o  out  1  one-cycle pulse when the last word has been written
hold_req_o  out  1  request to stall the PC and the pipeline during download

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low. Reset clears all control registers only; memory contents are not reset.
- Reset values: state=IDLE, word_cnt=0, byte_cnt=0, len_q=0, buffer=0. Outputs dl_ready_o=0, dl_busy_o=0, dl_done_o=0, hold_req_o=0.
- Fetch read path (combinational):
  - Index = pc_i[ADDR_W+1:2]; pc_i[1:0] is ignored.
  - If pc_i[31:ADDR_W+2] != 0, ins_o = NOP_INS.
  - If dl_busy_o = 1, ins_o = NOP_INS.
  - Otherwise ins_o = mem[index].
- Download FSM, states IDLE, RECV, WRITE, DONE:
  - IDLE:
    - On dl_start_i with dl_len_i != 0: len_q = min(dl_len_i, DEPTH), word_cnt = 0, byte_cnt = 0, go to RECV.
    - dl_start_i with dl_len_i == 0 is ignored: no busy, no done.
    - dl_valid_i is ignored.
  - RECV:
    - dl_ready_o = 1.
    - A byte is accepted when dl_valid_i && dl_ready_o. It is placed in buffer[8*byte_cnt +: 8] and byte_cnt increments.
    - The accept with byte_cnt == 3 moves to WRITE, byte_cnt back to 0.
    - dl_valid_i may have gaps of any length; state is held with no timeout.
  - WRITE:
    - dl_ready_o = 0 (one bubble per word).
    - At the edge: mem[word_cnt] = buffer.
    - If word_cnt == len_q-1, go to DONE; else word_cnt++ and return to RECV.
  - DONE: dl_done_o = 1 for this one cycle, then go to IDLE.
  - Fourth-byte timing: if the 4th byte of the last word is accepted at edge k, the write occurs at edge k+1, dl_done_o is high during the following cycle, and the FSM is in IDLE after edge k+2.
- dl_busy_o = hold_req_o = (state != IDLE).
- dl_start_i while busy is ignored; the current download continues unchanged.
- Reset mid-download: the FSM returns to IDLE immediately. Words already written stay written, the partial buffer is discarded, and no done pulse is generated.
- The memory has a single write port (download engine only) and a single combinational read port. There is no read/write conflict, because fetch returns NOP while busy.

Decomposition:
- Shared defines file: NOP_INS, the FSM state encodings, the default DEPTH/ADDR_W, and the hold-request encoding used when hold_req_o is merged into the core's 3-bit hold_flag.
- One natural sub-module: inst_ram, a DEPTH x 32 array with a synchronous write and an asynchronous read. It keeps the FSM separable from the storage, which may be mapped to distributed RAM.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> dl_busy_o=0, dl_ready_o=0, dl_done_o=0, hold_req_o=0; ins_o=mem[0] with pc_i=0.
- Basic download: dl_start_i, dl_len_i=2, then bytes 13 00 00 00 93 00 10 00 -> mem[0]=32'h00000013, mem[1]=32'h00100093; exactly one dl_done_o pulse 2 cycles after the last byte is accepted; afterwards pc_i=4 -> ins_o=32'h00100093.
- During busy: pc_i=4 -> ins_o=NOP_INS and hold_req_o=1 from the cycle after dl_start_i until the cycle after DONE. dl_valid_i toggling 1-0-0-1 gives no byte loss; dl_ready_o=0 in the WRITE cycle, and any byte offered then is not consumed.
- Ignored starts: dl_len_i=0 start -> no busy, no done. A second dl_start_i (dl_len_i=5) mid-download -> original len=2 completes after 8 bytes.
- Reset mid-download after 6 bytes of a 2-word load -> mem[0] updated, mem[1] unchanged; FSM in IDLE; no done pulse; a new download then succeeds.
- Bounds: pc_i=32'h0000_4000 (beyond 4096 words) -> NOP_INS. dl_len_i=16'hFFFF -> clamped to 4096 words; done after 16384 bytes.
